// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a processor (master) and the
// wait-state memory responder (slave).
//   req/we/adr/wdata : access request, sampled by the responder while idle
//   rdata/ready      : read data and one-cycle completion pulse
interface mem_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, adr, wdata, input  rdata, ready);
  modport slave  (input  req, we, adr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers processor accesses after
// WAIT_CYCLES wait states, counts completed writes and, when built with the
// MEM_CHECK_EN macro, flags a completion write (done) or an illegal write (fail).
// Ports:
//   clk       : clock, all state changes on rising edge
//   reset_n   : asynchronous active-low reset (storage contents are kept)
//   bus       : mem_responder_if.slave (req, we, adr, wdata -> rdata, ready)
//   done      : sticky, DONE_VALUE written to DONE_ADDR (MEM_CHECK_EN only)
//   fail      : sticky, illegal write seen (MEM_CHECK_EN only)
//   wr_count  : completed write count, saturating at 0xFFFF
// Build option: `define MEM_CHECK_EN to include the done/fail checker.
module mem_responder #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int DONE_ADDR    = 220,
  parameter int DONE_VALUE   = 7,
  parameter int SCRATCH_ADDR = 200
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_responder_if.slave      bus,
  output logic                done,
  output logic                fail,
  output logic [15:0]         wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic [15:0]         wr_count_q;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                ack_wr;
  assign ack_wr = (state_q == S_ACK) && we_q;

  // Storage has no reset: an aborted access never reaches S_ACK because the
  // async reset forces the FSM back to S_IDLE.
  always_ff @(posedge clk) begin
    if (ack_wr) mem[adr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            adr_q   <= bus.adr;
            wdata_q <= bus.wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
          end
        end
        S_WAIT: begin
          // Counter reaching 1 here means the next cycle is the access cycle.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_ACK;
        end
        S_ACK: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
          if (!we_q)                         rdata_q    <= mem[adr_q];
          else if (wr_count_q != 16'hFFFF)   wr_count_q <= wr_count_q + 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign wr_count  = wr_count_q;

`ifdef MEM_CHECK_EN
  logic done_q, fail_q;
  logic hit_done, hit_scratch;
  assign hit_done    = (adr_q == ADDR_W'(DONE_ADDR));
  assign hit_scratch = (adr_q == ADDR_W'(SCRATCH_ADDR));

  // First qualifying write decides the outcome; afterwards both flags freeze.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (ack_wr && !done_q && !fail_q) begin
      if (hit_done) begin
        if (wdata_q == DATA_W'(DONE_VALUE)) done_q <= 1'b1;
        else                                fail_q <= 1'b1;
      end else if (!hit_scratch) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign fail = fail_q;
`else
  assign done = 1'b0;
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
`ifdef MEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(13), .DATA_W(16)) bus0 ();
  mem_responder_if #(.ADDR_W(13), .DATA_W(16)) bus1 ();
  logic        done0, fail0, done1, fail1;
  logic [15:0] wrc0, wrc1;

  mem_responder #(.WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .done(done0), .fail(fail0), .wr_count(wrc0));
  mem_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .done(done1), .fail(fail1), .wr_count(wrc1));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One access on bus0; lat = edges from request-sampling edge to ready seen (-1 on timeout).
  task automatic access(input logic w, input logic [12:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat);
    @(posedge clk); #1;
    bus0.req = 1'b1; bus0.we = w; bus0.adr = a; bus0.wdata = d;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus0.ready) begin lat = k; rd = bus0.rdata; break; end
    end
  endtask

  logic [15:0] rd;
  int          lat;
  logic [7:0]  pat;
  int          npulse;
  logic        seen;

  initial begin
    bus0.req = 0; bus0.we = 0; bus0.adr = '0; bus0.wdata = '0;
    bus1.req = 0; bus1.we = 0; bus1.adr = '0; bus1.wdata = '0;
    do_reset();
    #1;
    chk("rst_ready", bus0.ready, 0);
    chk("rst_rdata", bus0.rdata, 0);
    chk("rst_wrc",   wrc0, 0);
    chk("rst_done",  done0, 0);
    chk("rst_fail",  fail0, 0);

    // Scratch write then read back
    access(1, 13'd200, 16'h1234, rd, lat);
    chk("wr200_lat", lat, 3);
    chk("wr200_wrc", wrc0, 1);
    chk("wr200_fail", fail0, 0);
    access(0, 13'd200, 16'h0000, rd, lat);
    chk("rd200_lat", lat, 3);
    chk("rd200_data", rd, 16'h1234);
    chk("rd200_wrc", wrc0, 1);
    @(posedge clk); #1;
    chk("ready_one_cycle", bus0.ready, 0);
    chk("rdata_held", bus0.rdata, 16'h1234);

    // Completion write, then a write elsewhere must not change sticky flags
    access(1, 13'd220, 16'd7, rd, lat);
    chk("done_set", done0, CHK);
    chk("done_nofail", fail0, 0);
    access(1, 13'd5, 16'h0055, rd, lat);
    chk("done_sticky", done0, CHK);
    chk("done_sticky_fail", fail0, 0);
    chk("wrc_3", wrc0, 3);

    // Wrong value first: fail wins and done never follows
    do_reset();
    access(1, 13'd220, 16'd8, rd, lat);
    access(1, 13'd220, 16'd7, rd, lat);
    chk("fail_set", fail0, CHK);
    chk("fail_nodone", done0, 0);

    // Reset during WAIT aborts the write
    access(1, 13'd10, 16'h1111, rd, lat);
    do_reset();
    @(posedge clk); #1;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.adr = 13'd10; bus0.wdata = 16'hBEEF;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= bus0.ready; end
    reset_n = 1'b1;
    chk("abort_noready", seen, 0);
    chk("abort_wrc", wrc0, 0);
    access(0, 13'd10, 16'h0000, rd, lat);
    chk("abort_keep_data", rd, 16'h1111);
    chk("abort_wrc_after", wrc0, 0);

    // req held through WAIT/ACK starts only one access
    @(posedge clk); #1;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.adr = 13'd200; bus0.wdata = 16'h00AA;
    npulse = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 3) bus0.req = 1'b0;
      if (bus0.ready) npulse++;
    end
    chk("wait_req_ignored", npulse, 1);
    chk("wait_req_wrc", wrc0, 1);

    // Zero wait states, req held 6 cycles: ready every second cycle
    @(posedge clk); #1;
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.adr = 13'd200; bus1.wdata = 16'h0001;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus1.req = 1'b0;
      pat[k] = bus1.ready;
    end
    chk("w0_pattern", pat, 8'b0010_1010);
    chk("w0_wrc", wrc1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each access completes (legal range 0..15).
REQ-004 SHALL have parameter DONE_ADDR, default 220, address watched for the completion write.
REQ-005 SHALL have parameter DONE_VALUE, default 7, data value that signals completion.
REQ-006 SHALL have parameter SCRATCH_ADDR, default 200, address where writes are always permitted.
REQ-007 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req, input, 1, access request from the processor.
REQ-010 SHALL have port we, input, 1, 1 = write, 0 = read; sampled with req.
REQ-011 SHALL have port adr, input, ADDR_W, word address; sampled with req.
REQ-012 SHALL have port wdata, input, DATA_W, write data; sampled with req.
REQ-013 SHALL have port rdata, output, DATA_W, read data; valid when ready=1 on a read.
REQ-014 SHALL have port ready, output, 1, one-cycle pulse marking access completion.
REQ-015 SHALL have port done, output, 1, sticky: DONE_VALUE written to DONE_ADDR.
REQ-016 SHALL have port fail, output, 1, sticky: illegal write detected.
REQ-017 SHALL have port wr_count, output, 16, count of completed writes.

Function
REQ-018 SHALL hold 2^ADDR_W words of DATA_W-bit storage; every ADDR_W-bit address is valid; no wrap or out-of-range case.
REQ-019 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-020 IDLE: on req=1, latch we/adr/wdata and load wait counter with WAIT_CYCLES; next state is WAIT if WAIT_CYCLES>0, else ACK.
REQ-021 WAIT: decrement counter each cycle; enter ACK on the cycle after the counter reaches 1.
REQ-022 ACK: perform the latched access, assert ready for exactly one cycle, return to IDLE.
REQ-023 req SHALL be ignored in WAIT and ACK; no queueing; a request held high across ACK starts a new access on the following IDLE cycle.
REQ-024 Latency: req sampled at edge N -> ready high in the cycle following edge N+WAIT_CYCLES+1.
REQ-025 Write: storage updated at the ACK edge with latched wdata; rdata unchanged.
REQ-026 Read: rdata loaded from storage at the ACK edge and held until the next read ACK.
REQ-027 A read immediately after a write to the same address SHALL return the new data.
REQ-028 wr_count SHALL increment on each write ACK and saturate at 0xFFFF.
REQ-029 Checker: a write ACK to DONE_ADDR with DONE_VALUE sets done; a write ACK to DONE_ADDR with another value, or to any address other than DONE_ADDR/SCRATCH_ADDR, sets fail.
REQ-030 done and fail are sticky; the first event wins; once either is set, neither flag changes until reset; storage writes continue.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state IDLE, counter 0, rdata 0, ready 0, done 0, fail 0, wr_count 0.
REQ-032 A reset during WAIT or ACK SHALL abort the access with no storage write and no ready pulse; storage contents are not cleared.
REQ-033 Reset release SHALL take effect at the first rising clk edge after reset_n rises.

Configuration
REQ-034 With MEM_CHECK_EN defined, the done/fail checker of REQ-029/030 SHALL be built.
REQ-035 Without MEM_CHECK_EN, done and fail SHALL be constant 0 with no checker logic; all other behaviour is unchanged.

Verification
REQ-036 Reset, WAIT_CYCLES=2, req write adr=200 wdata=0x1234 -> ready 3 cycles after request edge; wr_count=1; fail=0.
REQ-037 Read adr=200 after the REQ-036 write -> ready pulse with rdata=0x1234; wr_count remains 1.
REQ-038 Write adr=220 wdata=7 (MEM_CHECK_EN) -> done=1, fail=0; then write adr=5 -> done stays 1, fail stays 0.
REQ-039 Write adr=220 wdata=8, then adr=220 wdata=7 -> fail=1, done=0; same stimulus without MEM_CHECK_EN -> both 0.
REQ-040 WAIT_CYCLES=0, req held high for 6 cycles -> ready pulses every 2nd cycle; req toggles during WAIT are ignored.
REQ-041 reset_n low during WAIT of write adr=10 wdata=0xBEEF -> no ready pulse; a later read of adr=10 returns the prior value; wr_count=0.
